// File: rtl/rlbp_s2p_rx_pkg.sv
// Shared definitions for the RLBP serial receiver: register map, bit
// positions, receive FSM encoding and the STATUS word packer.
package rlbp_s2p_rx_pkg;

    localparam int unsigned WB_W      = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned SHREG_W   = BYTE_W - 1;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned BIT_CNT_W = 3;

    // Register offsets, selected by wbs_adr_i[3:2]
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;

    // STATUS bit positions
    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_FERR    = 3;
    localparam int unsigned ST_CNT_LSB = 8;

    // CONTROL bit positions
    localparam int unsigned CT_RX_EN  = 0;
    localparam int unsigned CT_IRQ_EN = 1;
    localparam int unsigned CT_FLUSH  = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic             frame_err;
        logic             overflow;
        logic             full;
        logic             empty;
    } status_t;

    // Place the status fields at their register bit positions
    function automatic logic [WB_W-1:0] status_word(input status_t s);
        logic [WB_W-1:0] w;
        w                        = '0;
        w[ST_EMPTY]              = s.empty;
        w[ST_FULL]               = s.full;
        w[ST_OVF]                = s.overflow;
        w[ST_FERR]               = s.frame_err;
        w[ST_CNT_LSB +: CNT_W]   = s.count;
        return w;
    endfunction

endpackage

// File: rtl/rlbp_rx_fifo.sv
// Synchronous byte FIFO for the RLBP receiver.
// Ports: clk/rst (sync, active-high); push/wr_data enqueue; pop dequeues the
// head shown on rd_data; flush empties it and overrides push/pop;
// full/empty/count report the registered occupancy.
// A push while full is accepted only if a pop happens in the same cycle.
module rlbp_rx_fifo
    import rlbp_s2p_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              pop,
    input  logic              flush,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    // Next-state: flush first, then concurrent push/pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/rlbp_s2p_rx.sv
// RLBP serial-to-parallel receiver with a Wishbone-readable FIFO.
// Ports: wb_clk_i/wb_rst_i (sync, active-high); wbs_* Wishbone slave
// (DATA/STATUS/CONTROL at wbs_adr_i[3:2], decoded when adr[31:28]==ADDR_HI);
// s_data_i/s_start_i MSB-first serial words, s_start_i marks the MSB;
// irq_o = irq_en AND FIFO not empty.
module rlbp_s2p_rx
    import rlbp_s2p_rx_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter logic [3:0]  ADDR_HI = 4'h4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [WB_W-1:0] wbs_dat_i,
    input  logic [WB_W-1:0] wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [WB_W-1:0] wbs_dat_o,
    input  logic            s_data_i,
    input  logic            s_start_i,
    output logic            irq_o
);

    rx_state_e              state_q, state_d;
    logic [SHREG_W-1:0]     shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   rx_en_q, rx_en_d;
    logic                   irq_en_q, irq_en_d;
    logic                   ovf_q, ovf_d;
    logic                   ferr_q, ferr_d;
    logic                   ack_q, ack_d;
    logic [WB_W-1:0]        dat_q, dat_d;

    logic                   push_c, pop_c, flush_c, ferr_set_c;
    logic [BYTE_W-1:0]      push_data_c;
    logic                   wb_accept_c, wb_rd_c, wb_wr_c;
    logic [1:0]             reg_sel_c;
    status_t                status_c;

    logic                   fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [BYTE_W-1:0]      fifo_rd_data;
    logic                   unused_c;

    // Wishbone decode; a new request is taken only while no ack is pending
    assign wb_accept_c = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:28] == ADDR_HI) && !ack_q;
    assign wb_rd_c     = wb_accept_c && !wbs_we_i;
    assign wb_wr_c     = wb_accept_c && wbs_we_i;
    assign reg_sel_c   = wbs_adr_i[3:2];

    assign status_c.count     = fifo_count;
    assign status_c.frame_err = ferr_q;
    assign status_c.overflow  = ovf_q;
    assign status_c.full      = fifo_full;
    assign status_c.empty     = fifo_empty;

    // Receive FSM: assemble MSB-first words, restart on any start marker
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        push_c      = 1'b0;
        push_data_c = {shreg_q, s_data_i};
        ferr_set_c  = 1'b0;

        if (!rx_en_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (s_start_i) begin
                        shreg_d = SHREG_W'(s_data_i);
                        cnt_d   = BIT_CNT_W'(1);
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (s_start_i) begin
                        // Early start: drop the partial word, current bit is the new MSB
                        ferr_set_c = 1'b1;
                        shreg_d    = SHREG_W'(s_data_i);
                        cnt_d      = BIT_CNT_W'(1);
                    end else if (cnt_q == '1) begin
                        push_c  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        shreg_d = {shreg_q[SHREG_W-2:0], s_data_i};
                        cnt_d   = cnt_q + BIT_CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Register file: read mux, writes, pop/flush strobes, sticky status
    always_comb begin
        ack_d    = wb_accept_c;
        dat_d    = dat_q;
        rx_en_d  = rx_en_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        ferr_d   = ferr_q;
        pop_c    = 1'b0;
        flush_c  = 1'b0;

        if (wb_rd_c) begin
            dat_d = '0;
            case (reg_sel_c)
                REG_DATA: begin
                    if (!fifo_empty) begin
                        dat_d = {23'b0, 1'b1, fifo_rd_data};
                        pop_c = 1'b1;
                    end
                end
                REG_STATUS: dat_d = status_word(status_c);
                REG_CONTROL: begin
                    dat_d[CT_RX_EN]  = rx_en_q;
                    dat_d[CT_IRQ_EN] = irq_en_q;
                end
                default: dat_d = '0;
            endcase
        end

        if (wb_wr_c) begin
            dat_d = '0;
            if (wbs_sel_i[0]) begin
                case (reg_sel_c)
                    REG_STATUS: begin
                        if (wbs_dat_i[ST_OVF])  ovf_d  = 1'b0;
                        if (wbs_dat_i[ST_FERR]) ferr_d = 1'b0;
                    end
                    REG_CONTROL: begin
                        rx_en_d  = wbs_dat_i[CT_RX_EN];
                        irq_en_d = wbs_dat_i[CT_IRQ_EN];
                        flush_c  = wbs_dat_i[CT_FLUSH];
                    end
                    default: ;
                endcase
            end
        end

        // A new event in the same cycle as a clear keeps the bit set
        if (push_c && fifo_full && !pop_c && !flush_c) ovf_d = 1'b1;
        if (ferr_set_c)                                ferr_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            rx_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            rx_en_q  <= rx_en_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    rlbp_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .push    (push_c),
        .wr_data (push_data_c),
        .pop     (pop_c),
        .flush   (flush_c),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_en_q && !fifo_empty;

    // Bus bits outside the decoded fields
    assign unused_c = ^{wbs_sel_i[3:1], wbs_dat_i[WB_W-1:4], wbs_adr_i[27:4], wbs_adr_i[1:0]};

endmodule
